// File: rtl/pu_queue_payload_ctrl.sv
// pu_queue_payload_ctrl: NUM_Q logical payload queues sharing one 1R1W block RAM.
// Each queue owns an equal RAM partition addressed as {qid, ptr}. Enqueue writes
// directly into the partition. A round-robin scheduler issues at most one read
// per cycle into a 2-entry output buffer that drives the valid/ready port.

// Block-RAM payload store: one write port, one registered read port.
module pu_queue_payload_ram #(
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [1<<AW];

    // Write on request; read data is registered (1-cycle latency). No reset on the array.
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

module pu_queue_payload_ctrl #(
    parameter int NUM_Q_NBITS = 2,
    parameter int DEPTH_NBITS = 6,
    parameter int PAYLOAD_W   = 8,
    localparam int NUM_Q         = 1 << NUM_Q_NBITS,
    localparam int Q_DEPTH_NBITS = DEPTH_NBITS - NUM_Q_NBITS,
    localparam int CW            = Q_DEPTH_NBITS + 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_Q-1:0]       i_q_enable,
    input  logic                   i_enq_req,
    input  logic [NUM_Q_NBITS-1:0] i_enq_qid,
    input  logic [PAYLOAD_W-1:0]   i_enq_data,
    output logic                   o_enq_drop,
    output logic                   o_deq_valid,
    output logic [NUM_Q_NBITS-1:0] o_deq_qid,
    output logic [PAYLOAD_W-1:0]   o_deq_data,
    input  logic                   i_deq_ready,
    output logic [NUM_Q*CW-1:0]    o_q_count
);
    localparam logic [CW-1:0] Q_SIZE = CW'(1 << Q_DEPTH_NBITS);

    // Per-queue pointers wrap naturally; count is the authoritative occupancy
    logic [CW-1:0] r_wr_ptr [NUM_Q];
    logic [CW-1:0] r_rd_ptr [NUM_Q];
    logic [CW-1:0] r_count  [NUM_Q];

    logic [NUM_Q_NBITS-1:0] r_last_q;
    logic                   r_infl;
    logic [NUM_Q_NBITS-1:0] r_rd_qid;
    logic                   r_enq_drop;

    // Output buffer: entry 0 is the head
    logic [1:0]             r_occ;
    logic [PAYLOAD_W-1:0]   r_buf_data [2];
    logic [NUM_Q_NBITS-1:0] r_buf_qid  [2];

    logic [NUM_Q-1:0]       w_full;
    logic [NUM_Q-1:0]       w_elig;
    logic [NUM_Q-1:0]       w_inc;
    logic [NUM_Q-1:0]       w_dec;
    logic                   w_enq_ok;
    logic                   w_pop;
    logic                   w_credit;
    logic                   w_any;
    logic                   w_issue;
    logic [NUM_Q_NBITS-1:0] w_win;
    logic [NUM_Q_NBITS-1:0] w_idx;
    logic [DEPTH_NBITS-1:0] w_waddr;
    logic [DEPTH_NBITS-1:0] w_raddr;
    logic [PAYLOAD_W-1:0]   w_ram_rdata;

    // Per-queue status from registered counts (fresh enqueues are not yet eligible)
    always_comb begin
        w_full = '0;
        w_elig = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            w_full[q] = (r_count[q] == Q_SIZE);
            w_elig[q] = (r_count[q] != '0) && i_q_enable[q];
        end
    end

    assign w_enq_ok = i_enq_req && !w_full[i_enq_qid];
    assign w_pop    = o_deq_valid && i_deq_ready;
    // Reserve a buffer slot for every read in flight so the buffer never overflows
    assign w_credit = (({1'b0, r_occ} + {2'b00, r_infl}) - {2'b00, w_pop}) < 3'd2;

    // Round-robin search starting after last_q; first eligible queue wins
    always_comb begin
        w_any = 1'b0;
        w_win = r_last_q;
        w_idx = '0;
        for (int k = 1; k <= NUM_Q; k++) begin
            w_idx = r_last_q + NUM_Q_NBITS'(k);
            if (!w_any && w_elig[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    assign w_issue = w_any && w_credit;
    assign w_waddr = {i_enq_qid, r_wr_ptr[i_enq_qid][Q_DEPTH_NBITS-1:0]};
    assign w_raddr = {w_win, r_rd_ptr[w_win][Q_DEPTH_NBITS-1:0]};

    // Per-queue increment/decrement strobes
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            w_inc[q] = w_enq_ok && (i_enq_qid == NUM_Q_NBITS'(q));
            w_dec[q] = w_issue && (w_win == NUM_Q_NBITS'(q));
        end
    end

    // Pointer and count update; simultaneous enqueue+issue leaves count unchanged
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int q = 0; q < NUM_Q; q++) begin
                r_wr_ptr[q] <= '0;
                r_rd_ptr[q] <= '0;
                r_count[q]  <= '0;
            end
        end else begin
            for (int q = 0; q < NUM_Q; q++) begin
                if (w_inc[q]) r_wr_ptr[q] <= r_wr_ptr[q] + CW'(1);
                if (w_dec[q]) r_rd_ptr[q] <= r_rd_ptr[q] + CW'(1);
                r_count[q] <= r_count[q] + CW'(w_inc[q]) - CW'(w_dec[q]);
            end
        end
    end

    // Scheduler state, read-in-flight tracking and drop flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_q   <= NUM_Q_NBITS'(NUM_Q - 1);
            r_infl     <= 1'b0;
            r_rd_qid   <= '0;
            r_enq_drop <= 1'b0;
        end else begin
            if (w_issue) begin
                r_last_q <= w_win;
                r_rd_qid <= w_win;
            end
            r_infl     <= w_issue;
            r_enq_drop <= i_enq_req && w_full[i_enq_qid];
        end
    end

    pu_queue_payload_ram #(
        .AW (DEPTH_NBITS),
        .DW (PAYLOAD_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_enq_ok),
        .i_waddr (w_waddr),
        .i_wdata (i_enq_data),
        .i_re    (w_issue),
        .i_raddr (w_raddr),
        .o_rdata (w_ram_rdata)
    );

    // 2-entry shift buffer: RAM dout is pushed the cycle after issue, head pops on transfer
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_occ <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_buf_data[i] <= '0;
                r_buf_qid[i]  <= '0;
            end
        end else begin
            case ({r_infl, w_pop})
                2'b01: begin
                    r_buf_data[0] <= r_buf_data[1];
                    r_buf_qid[0]  <= r_buf_qid[1];
                    r_occ         <= r_occ - 2'd1;
                end
                2'b10: begin
                    r_buf_data[r_occ[0]] <= w_ram_rdata;
                    r_buf_qid[r_occ[0]]  <= r_rd_qid;
                    r_occ                <= r_occ + 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_buf_data[0] <= w_ram_rdata;
                        r_buf_qid[0]  <= r_rd_qid;
                    end else begin
                        r_buf_data[0] <= r_buf_data[1];
                        r_buf_qid[0]  <= r_buf_qid[1];
                        r_buf_data[1] <= w_ram_rdata;
                        r_buf_qid[1]  <= r_rd_qid;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_deq_valid = (r_occ != 2'd0);
    assign o_deq_data  = r_buf_data[0];
    assign o_deq_qid   = r_buf_qid[0];
    assign o_enq_drop  = r_enq_drop;

    // Export per-queue counts, queue 0 in the LSBs
    always_comb begin
        o_q_count = '0;
        for (int q = 0; q < NUM_Q; q++) o_q_count[q*CW +: CW] = r_count[q];
    end
endmodule

// File: tb/tb_pu_queue_payload_ctrl.sv
// Randomized + directed bench for pu_queue_payload_ctrl with a queue-based
// reference model and a decoupled output scoreboard.
module tb_pu_queue_payload_ctrl;
    localparam int NQB = 2;
    localparam int DNB = 6;
    localparam int NQ  = 4;
    localparam int CW  = 5;
    localparam int QS  = 16;

    logic            clk;
    logic            rst;
    logic [NQ-1:0]   q_enable;
    logic            enq_req;
    logic [NQB-1:0]  enq_qid;
    logic [7:0]      enq_data;
    logic            enq_drop;
    logic            deq_valid;
    logic [NQB-1:0]  deq_qid;
    logic [7:0]      deq_data;
    logic            deq_ready;
    logic [NQ*CW-1:0] q_count;

    typedef struct packed {
        logic [NQB-1:0] qid;
        logic [7:0]     data;
    } item_t;

    // Reference model state
    logic [7:0] mq [NQ][$];
    item_t      mbuf[$];
    item_t      sb[$];
    logic       minfl;
    item_t      minfl_item;
    int         mlast;
    logic       mdrop;

    int checks;
    int failures;

    pu_queue_payload_ctrl #(.NUM_Q_NBITS(NQB), .DEPTH_NBITS(DNB), .PAYLOAD_W(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_q_enable  (q_enable),
        .i_enq_req   (enq_req),
        .i_enq_qid   (enq_qid),
        .i_enq_data  (enq_data),
        .o_enq_drop  (enq_drop),
        .o_deq_valid (deq_valid),
        .o_deq_qid   (deq_qid),
        .o_deq_data  (deq_data),
        .i_deq_ready (deq_ready),
        .o_q_count   (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qcnt(input int q);
        return int'(q_count[q*CW +: CW]);
    endfunction

    task automatic model_reset();
        for (int q = 0; q < NQ; q++) mq[q].delete();
        mbuf.delete();
        minfl = 1'b0;
        minfl_item = '0;
        mlast = NQ - 1;
        mdrop = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs currently driven
    task automatic model_step();
        bit    pop;
        bit    credit;
        bit    full;
        bit    any;
        int    win;
        int    q;
        item_t nx;
        bit    nx_infl;
        pop    = (mbuf.size() > 0) && deq_ready;
        credit = (mbuf.size() + int'(minfl) - int'(pop)) < 2;
        full   = (mq[enq_qid].size() == QS);
        any = 0;
        win = 0;
        for (int k = 1; k <= NQ; k++) begin
            q = (mlast + k) % NQ;
            if (!any && mq[q].size() > 0 && q_enable[q]) begin
                any = 1;
                win = q;
            end
        end
        nx = '0;
        nx_infl = 0;
        if (any && credit) begin
            nx.qid  = NQB'(win);
            nx.data = mq[win].pop_front();
            mlast   = win;
            nx_infl = 1;
        end
        if (pop) sb.push_back(mbuf.pop_front());
        if (minfl) begin
            if (mbuf.size() >= 2) begin
                failures++;
                $display("FAIL buf_overflow actual=%0d required<2", mbuf.size());
            end
            mbuf.push_back(minfl_item);
        end
        mdrop = enq_req && full;
        if (enq_req && !full) mq[enq_qid].push_back(enq_data);
        minfl      = nx_infl;
        minfl_item = nx;
    endtask

    task automatic check_outputs();
        chk("deq_valid", int'(deq_valid), int'(mbuf.size() > 0));
        chk("enq_drop", int'(enq_drop), int'(mdrop));
        for (int q = 0; q < NQ; q++) chk($sformatf("q_count%0d", q), qcnt(q), mq[q].size());
    endtask

    // One cycle: check this cycle's outputs, then drive its inputs
    task automatic step(input bit req, input int qid, input int data, input bit rdy, input logic [NQ-1:0] en);
        @(negedge clk);
        check_outputs();
        enq_req   = req;
        enq_qid   = NQB'(qid);
        enq_data  = data[7:0];
        deq_ready = rdy;
        q_enable  = en;
        model_step();
    endtask

    task automatic idle(input int n, input bit rdy, input logic [NQ-1:0] en);
        for (int i = 0; i < n; i++) step(0, 0, 0, rdy, en);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        enq_req = 1'b0;
        model_reset();
        #1;
        chk("rst_deq_valid", int'(deq_valid), 0);
        for (int q = 0; q < NQ; q++) chk($sformatf("rst_q_count%0d", q), qcnt(q), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compare every transfer against the scoreboard
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            #2;
            if (deq_valid === 1'b1 && deq_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_deq actual_qid=%0d actual_data=%0h required=none", deq_qid, deq_data);
                end else begin
                    it = sb.pop_front();
                    chk("deq_qid", int'(deq_qid), int'(it.qid));
                    chk("deq_data", int'(deq_data), int'(it.data));
                end
            end
        end
    end

    initial begin
        int sum;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        q_enable = '0;
        enq_req = 1'b0;
        enq_qid = '0;
        enq_data = '0;
        deq_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        step(0, 0, 0, 1, 4'hF);
        chk("reset_deq_valid", int'(deq_valid), 0);
        chk("reset_enq_drop", int'(enq_drop), 0);
        chk("reset_q_count", int'(q_count), 0);

        // Minimum latency: enqueue 0xA5 to q2 in cycle 0
        step(1, 2, 8'hA5, 1, 4'hF);
        step(0, 0, 0, 1, 4'hF);
        chk("lat_count_c1", qcnt(2), 1);
        step(0, 0, 0, 1, 4'hF);
        chk("lat_count_c2", qcnt(2), 0);
        chk("lat_valid_c2", int'(deq_valid), 0);
        step(0, 0, 0, 1, 4'hF);
        chk("lat_valid_c3", int'(deq_valid), 1);
        chk("lat_qid_c3", int'(deq_qid), 2);
        chk("lat_data_c3", int'(deq_data), 8'hA5);
        idle(4, 1, 4'hF);

        // Fill q1, overflow by one, then drain in order
        for (int i = 0; i < QS; i++) step(1, 1, i, 1, 4'h0);
        chk("full_count", qcnt(1), QS - 1);
        step(1, 1, 8'hFF, 1, 4'h0);
        step(0, 0, 0, 1, 4'h0);
        chk("drop_pulse", int'(enq_drop), 1);
        step(0, 0, 0, 1, 4'h0);
        chk("drop_once", int'(enq_drop), 0);
        idle(24, 1, 4'hF);

        // Preload 3 per queue, then round-robin drain with no bubbles
        for (int r = 0; r < 3; r++)
            for (int q = 0; q < NQ; q++) step(1, q, $urandom_range(0, 255), 1, 4'h0);
        idle(18, 1, 4'hF);

        // Same preload with consumer stalled for 10 cycles
        for (int r = 0; r < 3; r++)
            for (int q = 0; q < NQ; q++) step(1, q, $urandom_range(0, 255), 0, 4'h0);
        idle(10, 0, 4'hF);
        sum = 0;
        for (int q = 0; q < NQ; q++) sum += qcnt(q);
        chk("stall_total_count", sum, 10);
        idle(18, 1, 4'hF);

        // q2 disabled while loaded; q0 gets a concurrent enqueue every cycle
        for (int r = 0; r < 4; r++)
            for (int q = 0; q < NQ; q++) step(1, q, $urandom_range(0, 255), 1, 4'h0);
        for (int i = 0; i < 10; i++) step(1, 0, $urandom_range(0, 255), 1, 4'b1011);
        chk("q2_held", qcnt(2), 4);
        idle(30, 1, 4'hF);

        // Reset with one buffered entry and one read in flight
        for (int q = 0; q < NQ; q++) step(1, q, 8'h50 + q, 0, 4'h0);
        idle(2, 0, 4'hF);
        do_reset();
        step(1, 3, 8'h3C, 1, 4'hF);
        idle(6, 1, 4'hF);

        // Randomized traffic, one mid-run reset
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            step($urandom_range(0, 3) != 0, $urandom_range(0, NQ - 1), $urandom_range(0, 255),
                 $urandom_range(0, 2) != 0, (i % 40 < 30) ? 4'hF : NQ'($urandom_range(0, 15)));
        end
        idle(80, 1, 4'hF);
        @(negedge clk);
        #3;
        chk("scoreboard_drained", sb.size(), 0);
        chk("model_buf_drained", mbuf.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
